// File: rtl/controle_posicionamento.sv
// Ship-placement sequencer: moves/rotates the current ship, checks it against the
// occupancy map one cell per cycle, then commits it and advances to the next ship.
module controle_posicionamento #(
    parameter int TAM_PA = 5,
    parameter int TAM_EN = 4,
    parameter int TAM_CR = 3,
    parameter int TAM_HI = 3,
    parameter int TAM_SU = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    input  logic        btn_confirm,
    output logic [63:0] posPortaAvioes,
    output logic [63:0] posEncouracado,
    output logic [63:0] posCruzador,
    output logic [63:0] posHidroaviao,
    output logic [63:0] posSubmarino,
    output logic [63:0] ocupacao,
    output logic [2:0]  navioAtual,
    output logic        ocupado,
    output logic        erro,
    output logic        concluido
);

    typedef enum logic [1:0] {PLACE, CHECK, COMMIT, DONE} estado_t;

    estado_t          estado;
    logic [3:0]       anchorX;
    logic [3:0]       anchorY;
    logic             vertical;
    logic [2:0]       indice;
    logic [4:0][63:0] posReg;

    logic [4:0]  tamanho;
    logic [4:0]  ext;
    logic [4:0]  fimX;
    logic [4:0]  fimY;
    logic [4:0]  rotX;
    logic [4:0]  rotY;
    logic        cabeRot;
    logic [3:0]  nextX;
    logic [3:0]  nextY;
    logic        nextVert;
    logic [63:0] previewNext;
    logic [63:0] mascara;
    logic [3:0]  checkX;
    logic [3:0]  checkY;
    logic [5:0]  idxCheck;

    function automatic logic [4:0] tamanhoDe(input logic [2:0] n);
        case (n)
            3'd0:    return 5'(TAM_PA);
            3'd1:    return 5'(TAM_EN);
            3'd2:    return 5'(TAM_CR);
            3'd3:    return 5'(TAM_HI);
            3'd4:    return 5'(TAM_SU);
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [5:0] indiceCelula(input logic [3:0] x, input logic [3:0] y);
        return 6'(({2'b00, y} - 6'd1) * 6'd8 + ({2'b00, x} - 6'd1));
    endfunction

    function automatic logic [63:0] montaVetor(input logic [3:0] ax, input logic [3:0] ay,
                                               input logic vert, input logic [4:0] tam);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 5; k++) begin
            if (5'(k) < tam) begin
                v[3+8*k +: 4] = ax + (vert ? 4'd0 : 4'(k));
                v[7+8*k +: 4] = ay + (vert ? 4'(k) : 4'd0);
            end
        end
        return v;
    endfunction

    function automatic logic [63:0] montaMascara(input logic [3:0] ax, input logic [3:0] ay,
                                                 input logic vert, input logic [4:0] tam);
        logic [63:0] m;
        m = '0;
        for (int k = 0; k < 5; k++) begin
            if (5'(k) < tam) begin
                m[indiceCelula(ax + (vert ? 4'd0 : 4'(k)), ay + (vert ? 4'(k) : 4'd0))] = 1'b1;
            end
        end
        return m;
    endfunction

    // Far-end coordinates are kept in 5 bits so an off-board result never wraps back in range.
    always_comb begin
        tamanho  = tamanhoDe(navioAtual);
        ext      = tamanho - 5'd1;
        fimX     = {1'b0, anchorX} + (vertical ? 5'd0 : ext);
        fimY     = {1'b0, anchorY} + (vertical ? ext : 5'd0);
        rotX     = {1'b0, anchorX} + ext;
        rotY     = {1'b0, anchorY} + ext;
        cabeRot  = vertical ? (rotX <= 5'd8) : (rotY <= 5'd8);
        nextX    = anchorX;
        nextY    = anchorY;
        nextVert = vertical;
        if (btn_confirm) begin
            nextX = anchorX;
        end else if (btn_rotate) begin
            if (cabeRot) nextVert = ~vertical;
        end else if (btn_up) begin
            if (fimY + 5'd1 <= 5'd8) nextY = anchorY + 4'd1;
        end else if (btn_down) begin
            if (anchorY > 4'd1) nextY = anchorY - 4'd1;
        end else if (btn_left) begin
            if (anchorX > 4'd1) nextX = anchorX - 4'd1;
        end else if (btn_right) begin
            if (fimX + 5'd1 <= 5'd8) nextX = anchorX + 4'd1;
        end
        previewNext = montaVetor(nextX, nextY, nextVert, tamanho);
        mascara     = montaMascara(anchorX, anchorY, vertical, tamanho);
        checkX      = anchorX + (vertical ? 4'd0 : {1'b0, indice});
        checkY      = anchorY + (vertical ? {1'b0, indice} : 4'd0);
        idxCheck    = indiceCelula(checkX, checkY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= PLACE;
            anchorX    <= 4'd1;
            anchorY    <= 4'd1;
            vertical   <= 1'b0;
            indice     <= 3'd0;
            navioAtual <= 3'd0;
            posReg     <= '0;
            ocupacao   <= '0;
            ocupado    <= 1'b0;
            erro       <= 1'b0;
            concluido  <= 1'b0;
        end else begin
            erro <= 1'b0;
            case (estado)
                PLACE: begin
                    anchorX  <= nextX;
                    anchorY  <= nextY;
                    vertical <= nextVert;
                    for (int n = 0; n < 5; n++) begin
                        if (navioAtual == 3'(n)) posReg[n] <= previewNext;
                    end
                    if (btn_confirm) begin
                        estado  <= CHECK;
                        indice  <= 3'd0;
                        ocupado <= 1'b1;
                    end else if (btn_rotate && !cabeRot) begin
                        erro <= 1'b1;
                    end
                end
                CHECK: begin
                    if (ocupacao[idxCheck]) begin
                        erro    <= 1'b1;
                        ocupado <= 1'b0;
                        estado  <= PLACE;
                    end else if ({2'b00, indice} == ext) begin
                        estado <= COMMIT;
                    end else begin
                        indice <= indice + 3'd1;
                    end
                end
                COMMIT: begin
                    ocupacao   <= ocupacao | mascara;
                    navioAtual <= navioAtual + 3'd1;
                    anchorX    <= 4'd1;
                    anchorY    <= 4'd1;
                    vertical   <= 1'b0;
                    ocupado    <= 1'b0;
                    if (navioAtual == 3'd4) begin
                        estado    <= DONE;
                        concluido <= 1'b1;
                    end else begin
                        estado <= PLACE;
                    end
                end
                default: begin
                    concluido <= 1'b1;
                end
            endcase
        end
    end

    assign posPortaAvioes = posReg[0];
    assign posEncouracado = posReg[1];
    assign posCruzador    = posReg[2];
    assign posHidroaviao  = posReg[3];
    assign posSubmarino   = posReg[4];

endmodule

// File: tb/tb_controle_posicionamento.sv
// Directed bench for the ship-placement sequencer; expected vectors are hand-packed
// as five bytes {Y,X} per cell, cell 0 in the lowest byte.
module tb_controle_posicionamento;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        btn_rotate = 1'b0, btn_confirm = 1'b0;
    logic [63:0] posPortaAvioes, posEncouracado, posCruzador, posHidroaviao, posSubmarino;
    logic [63:0] ocupacao;
    logic [2:0]  navioAtual;
    logic        ocupado, erro, concluido;

    int compared = 0;
    int mismatched = 0;

    controle_posicionamento dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_rotate(btn_rotate), .btn_confirm(btn_confirm),
        .posPortaAvioes(posPortaAvioes), .posEncouracado(posEncouracado),
        .posCruzador(posCruzador), .posHidroaviao(posHidroaviao), .posSubmarino(posSubmarino),
        .ocupacao(ocupacao), .navioAtual(navioAtual), .ocupado(ocupado),
        .erro(erro), .concluido(concluido)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [39:0] cells);
        return {21'd0, cells, 3'd0};
    endfunction

    // Buttons in order {confirm, rotate, up, down, left, right}, held across one rising edge.
    task automatic pulse(input logic [5:0] b);
        @(negedge clk);
        {btn_confirm, btn_rotate, btn_up, btn_down, btn_left, btn_right} = b;
        @(negedge clk);
        {btn_confirm, btn_rotate, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    endtask

    task automatic repeatPulse(input logic [5:0] b, input int n);
        for (int i = 0; i < n; i++) pulse(b);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (ocupado && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic placeShip(input int ups);
        int c;
        repeatPulse(6'b001000, ups);
        pulse(6'b100000);
        waitIdle(c);
        compared++;
        if (c >= 40) begin
            mismatched++;
            $display("[TB] FAIL place_timeout: ocupado stuck after %0d cycles, required release", c);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({posPortaAvioes, posEncouracado, posCruzador, posHidroaviao, posSubmarino} !== '0 ||
            ocupacao !== 64'd0 || navioAtual !== 3'd0 || {ocupado, erro, concluido} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_values: pa=%h nav=%0d flags=%b, required all zero", posPortaAvioes,
                     navioAtual, {ocupado, erro, concluido});
        end
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (posPortaAvioes !== mk(40'h15_14_13_12_11) || posEncouracado !== 64'd0 || navioAtual !== 3'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_preview: pa=%h en=%h nav=%0d, required pa=%h en=0 nav=0",
                     posPortaAvioes, posEncouracado, navioAtual, mk(40'h15_14_13_12_11));
        end
    endtask

    task automatic test_priority();
        doReset();
        pulse(6'b000010);
        compared++;
        if (posPortaAvioes !== mk(40'h15_14_13_12_11) || erro !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL left_edge: pa=%h erro=%b, required %h erro=0", posPortaAvioes, erro,
                     mk(40'h15_14_13_12_11));
        end
        pulse(6'b001001);
        compared++;
        if (posPortaAvioes !== mk(40'h25_24_23_22_21)) begin
            mismatched++;
            $display("[TB] FAIL up_over_right: pa=%h, required %h", posPortaAvioes, mk(40'h25_24_23_22_21));
        end
    endtask

    task automatic test_move_rotate();
        doReset();
        repeatPulse(6'b000001, 4);
        compared++;
        if (posPortaAvioes !== mk(40'h18_17_16_15_14)) begin
            mismatched++;
            $display("[TB] FAIL right_x4: pa=%h, required %h", posPortaAvioes, mk(40'h18_17_16_15_14));
        end
        pulse(6'b000001);
        compared++;
        if (posPortaAvioes !== mk(40'h18_17_16_15_14) || erro !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL right_edge: pa=%h erro=%b, required %h erro=0", posPortaAvioes, erro,
                     mk(40'h18_17_16_15_14));
        end
        pulse(6'b010000);
        compared++;
        if (posPortaAvioes !== mk(40'h54_44_34_24_14) || erro !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rotate_ok: pa=%h erro=%b, required %h erro=0", posPortaAvioes, erro,
                     mk(40'h54_44_34_24_14));
        end
    endtask

    task automatic test_rotate_reject();
        repeatPulse(6'b000001, 4);
        repeatPulse(6'b001000, 4);
        compared++;
        if (posPortaAvioes !== mk(40'h88_78_68_58_48)) begin
            mismatched++;
            $display("[TB] FAIL top_edge: pa=%h, required %h", posPortaAvioes, mk(40'h88_78_68_58_48));
        end
        pulse(6'b010000);
        compared++;
        if (erro !== 1'b1 || posPortaAvioes !== mk(40'h88_78_68_58_48)) begin
            mismatched++;
            $display("[TB] FAIL rotate_reject: erro=%b pa=%h, required erro=1 pa=%h", erro, posPortaAvioes,
                     mk(40'h88_78_68_58_48));
        end
        @(negedge clk);
        compared++;
        if (erro !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL erro_width: erro=%b, required 0", erro);
        end
    endtask

    task automatic test_commit();
        int c;
        doReset();
        pulse(6'b100000);
        waitIdle(c);
        compared++;
        if (c !== 6) begin
            mismatched++;
            $display("[TB] FAIL busy_cycles: got %0d, required 6", c);
        end
        compared++;
        if (ocupacao !== 64'h1F || navioAtual !== 3'd1 || posPortaAvioes !== mk(40'h15_14_13_12_11)) begin
            mismatched++;
            $display("[TB] FAIL commit_ship0: ocup=%h nav=%0d pa=%h, required 1f 1 %h", ocupacao, navioAtual,
                     posPortaAvioes, mk(40'h15_14_13_12_11));
        end
        @(negedge clk);
        compared++;
        if (posEncouracado !== mk(40'h00_14_13_12_11)) begin
            mismatched++;
            $display("[TB] FAIL preview_ship1: en=%h, required %h", posEncouracado, mk(40'h00_14_13_12_11));
        end
    endtask

    task automatic test_overlap();
        repeatPulse(6'b000001, 2);
        pulse(6'b100000);
        @(negedge clk);
        compared++;
        if (erro !== 1'b1 || ocupado !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL overlap_reject: erro=%b ocupado=%b, required 1 0", erro, ocupado);
        end
        @(negedge clk);
        compared++;
        if (posEncouracado !== mk(40'h00_16_15_14_13) || navioAtual !== 3'd1 || ocupacao !== 64'h1F) begin
            mismatched++;
            $display("[TB] FAIL overlap_keep: en=%h nav=%0d ocup=%h, required %h 1 1f", posEncouracado,
                     navioAtual, ocupacao, mk(40'h00_16_15_14_13));
        end
        placeShip(1);
        compared++;
        if (ocupacao !== 64'h3C1F || navioAtual !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL commit_ship1: ocup=%h nav=%0d, required 3c1f 2", ocupacao, navioAtual);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int s = 0; s < 5; s++) placeShip(s);
        compared++;
        if (concluido !== 1'b1 || navioAtual !== 3'd5 || ocupacao !== 64'h0000_0003_0707_0F1F) begin
            mismatched++;
            $display("[TB] FAIL all_done: conc=%b nav=%0d ocup=%h, required 1 5 0000000307070f1f", concluido,
                     navioAtual, ocupacao);
        end
        compared++;
        if (posSubmarino !== mk(40'h00_00_00_52_51) || posHidroaviao !== mk(40'h00_00_43_42_41)) begin
            mismatched++;
            $display("[TB] FAIL latched_vectors: su=%h hi=%h, required %h %h", posSubmarino, posHidroaviao,
                     mk(40'h00_00_00_52_51), mk(40'h00_00_43_42_41));
        end
        pulse(6'b100001);
        pulse(6'b010000);
        compared++;
        if (concluido !== 1'b1 || navioAtual !== 3'd5 || ocupacao !== 64'h0000_0003_0707_0F1F ||
            erro !== 1'b0 || ocupado !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL done_ignores: conc=%b nav=%0d ocup=%h erro=%b, required 1 5 unchanged 0",
                     concluido, navioAtual, ocupacao, erro);
        end
    endtask

    task automatic test_reset_mid_check();
        doReset();
        placeShip(0);
        placeShip(1);
        repeatPulse(6'b001000, 2);
        pulse(6'b100000);
        @(negedge clk);
        compared++;
        if (ocupado !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_check_busy: ocupado=%b, required 1", ocupado);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compared++;
        if ({posPortaAvioes, posEncouracado, posCruzador} !== '0 || ocupacao !== 64'd0 ||
            navioAtual !== 3'd0 || {ocupado, erro, concluido} !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_mid_check: ocup=%h nav=%0d flags=%b, required all zero", ocupacao,
                     navioAtual, {ocupado, erro, concluido});
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_move_rotate();
        test_rotate_reject();
        test_commit();
        test_overlap();
        test_back_to_back();
        test_reset_mid_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
